// File: rtl/regfile_pkg.sv
// Shared defaults and sizing helper for the parametrised register file and its debug scanner.
package regfile_pkg;

  localparam int DATA_W_DEF   = 8;
  localparam int ADDR_W_DEF   = 3;
  localparam int SCAN_DIV_DEF = 50_000_000;

  // Bits needed to count 0..value-1, never less than one bit.
  function automatic int clog2(input int value);
    int w;
    w = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) w = i + 1;
    end
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/regfile_scan.sv
// Round-robin debug scanner: divides clk down to one step every SCAN_DIV enabled cycles
// and walks dbg_addr across the whole register array.
module regfile_scan
  import regfile_pkg::*;
#(
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int SCAN_DIV = SCAN_DIV_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              dbg_en,
  output logic [ADDR_W-1:0] dbg_addr,
  output logic              dbg_step
);

  localparam int CNT_W = clog2(SCAN_DIV);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCAN_DIV - 1);

  logic [CNT_W-1:0] div_cnt;
  logic             wrap;

  assign wrap = dbg_en && (div_cnt == CNT_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt  <= '0;
      dbg_addr <= '0;
      dbg_step <= 1'b0;
    end else begin
      dbg_step <= wrap;
      if (dbg_en) div_cnt <= wrap ? '0 : div_cnt + 1'b1;
      if (wrap) dbg_addr <= dbg_addr + 1'b1;
    end
  end

endmodule

// File: rtl/regfile_param.sv
// 2-read/1-write register file with optional zero register, optional write bypass,
// a registered debug view driven by the scanner, and a flat dump of the whole array.
module regfile_param
  import regfile_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int ZERO_REG = 0,
  parameter int BYPASS   = 0,
  parameter int SCAN_DIV = SCAN_DIV_DEF
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            we3,
  input  logic [ADDR_W-1:0]               wa3,
  input  logic [DATA_W-1:0]               wd3,
  input  logic [ADDR_W-1:0]               ra1,
  input  logic [ADDR_W-1:0]               ra2,
  output logic [DATA_W-1:0]               rd1,
  output logic [DATA_W-1:0]               rd2,
  input  logic                            dbg_en,
  output logic [ADDR_W-1:0]               dbg_addr,
  output logic [DATA_W-1:0]               dbg_data,
  output logic                            dbg_step,
  output logic [DATA_W*(2**ADDR_W)-1:0]   all_regs
);

  localparam int DEPTH = 2**ADDR_W;

  logic [DATA_W-1:0] regs [DEPTH];
  logic [DATA_W-1:0] dbg_data_p1;
  logic              wr_ok;

  // A write to register 0 is swallowed when it is hard-wired to zero; this also
  // keeps it out of the bypass path.
  assign wr_ok = we3 && !(ZERO_REG != 0 && wa3 == '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
    end else if (wr_ok) begin
      regs[wa3] <= wd3;
    end
  end

  always_comb begin
    rd1 = regs[ra1];
    if (BYPASS != 0 && wr_ok && ra1 == wa3) rd1 = wd3;
    if (ZERO_REG != 0 && ra1 == '0) rd1 = '0;
  end

  always_comb begin
    rd2 = regs[ra2];
    if (BYPASS != 0 && wr_ok && ra2 == wa3) rd2 = wd3;
    if (ZERO_REG != 0 && ra2 == '0) rd2 = '0;
  end

  regfile_scan #(
    .ADDR_W   (ADDR_W),
    .SCAN_DIV (SCAN_DIV)
  ) u_scan (
    .clk      (clk),
    .rst      (rst),
    .dbg_en   (dbg_en),
    .dbg_addr (dbg_addr),
    .dbg_step (dbg_step)
  );

  // Stage p1: debug view sampled from the array one cycle behind dbg_addr
  always_ff @(posedge clk) begin
    if (rst) begin
      dbg_data_p1 <= '0;
    end else if (ZERO_REG != 0 && dbg_addr == '0) begin
      dbg_data_p1 <= '0;
    end else begin
      dbg_data_p1 <= regs[dbg_addr];
    end
  end

  assign dbg_data = dbg_data_p1;

  always_comb begin
    all_regs = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (!(ZERO_REG != 0 && i == 0)) all_regs[i*DATA_W +: DATA_W] = regs[i];
    end
  end

endmodule
